// File: rtl/rr_arb32_32.sv
// 32-requester round-robin arbiter that captures the granted word into a
// valid/ready output register. Optional grant locking: define RR_ARB32_LOCK_EN.
module rr_arb32_32 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          in_req,
  input  logic [32*WIDTH-1:0]  in_data,
`ifdef RR_ARB32_LOCK_EN
  input  logic [31:0]          in_lock,
`endif
  output logic [31:0]          in_ack,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [4:0]           out_sel
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [4:0]        ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [4:0]        sel_q, sel_d;
  logic [31:0]       ack_q, ack_d;
  logic              lock_q, lock_d;

  logic [4:0]        cand;
  logic [4:0]        grant_idx;
  logic              grant_found;

  // Search upward from ptr+1; 5-bit arithmetic provides the wrap for free.
  always_comb begin
    cand        = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < 32; k++) begin
      cand = ptr_q + 5'd1 + 5'(k);
      if (!grant_found && in_req[cand]) begin
        grant_idx   = cand;
        grant_found = 1'b1;
      end
    end
`ifdef RR_ARB32_LOCK_EN
    // ptr holds the last granted index, so a stored lock regrants it directly.
    if (lock_q && in_req[ptr_q]) begin
      grant_idx   = ptr_q;
      grant_found = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ack_d   = '0;
    lock_d  = lock_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = GRANT;
          valid_d = 1'b1;
          data_d  = in_data[grant_idx*WIDTH +: WIDTH];
          sel_d   = grant_idx;
          ack_d   = 32'd1 << grant_idx;
`ifdef RR_ARB32_LOCK_EN
          lock_d  = in_lock[grant_idx];
`else
          lock_d  = 1'b0;
`endif
        end
      end
      GRANT: begin
        if (valid_q && out_ready) begin
          ptr_d   = sel_q;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 5'd31;
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ack_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      lock_q  <= lock_d;
    end
  end

  assign in_ack    = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: doc/rr_arb32_32.md
RR_ARB32_32 -- requirements
Module: rr_arb32_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the per-requester data width; the requester count is fixed at 32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_req, input, 32 bits: bit i is the request from requester i.
REQ-005 SHALL have port in_data, input, 32*WIDTH bits: requester i's word occupies bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port in_ack, output, 32 bits: a one-hot, one-cycle pulse telling the requester its word was captured.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data and out_sel are valid.
REQ-008 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the word.
REQ-009 SHALL have port out_data, output, WIDTH bits: the captured word.
REQ-010 SHALL have port out_sel, output, 5 bits: the index of the granted requester.

Function
REQ-011 SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-012 In IDLE with in_req nonzero, SHALL choose the granted index g as the first set bit searching upward from (ptr+1) mod 32, wrapping.
REQ-013 On that same edge SHALL do all of the following:
- register out_data from in_data slice g;
- register out_sel = g;
- set out_valid = 1;
- pulse in_ack[g] for exactly the first GRANT cycle;
- move to GRANT.
Grant latency is 1 cycle from the request being sampled.
REQ-014 In IDLE with in_req = 0, SHALL stay in IDLE with out_valid = 0 and in_ack = 0.
REQ-015 In GRANT, out_data and out_sel SHALL stay stable until a handshake (out_valid & out_ready).
REQ-016 On handshake SHALL set ptr = out_sel, clear out_valid and return to IDLE, giving at most one transfer per 2 cycles.
REQ-017 If out_ready is already high in the first GRANT cycle, the handshake SHALL complete that cycle.
REQ-018 Changes on in_req or in_data during GRANT SHALL be ignored.
REQ-019 Requesters SHALL hold req and data until their ack.
- A requester that drops req before its ack simply loses the arbitration.
- A requester whose req is still high after its ack is treated as a new request.
REQ-020 Fairness: a continuously requesting requester SHALL be granted within 32 grants.
REQ-021 With all 32 requesting, grants SHALL follow 0, 1, …, 31, 0, …
REQ-022 ptr SHALL wrap from 31 to 0 with no special case.

Reset
REQ-023 While rst = 1 at a clock edge, SHALL set state = IDLE, ptr = 31, out_valid = 0, out_data = 0, out_sel = 0 and in_ack = 0.
REQ-024 Reset asserted in GRANT SHALL drop the pending word without a handshake; the first post-reset grant SHALL search from index 0.
REQ-025 in_ack SHALL NOT pulse during or in the cycle after reset unless a new grant occurs.

Configuration
REQ-026 Macro RR_ARB32_LOCK_EN SHALL compile in a 32-bit input port in_lock.
REQ-027 With RR_ARB32_LOCK_EN defined:
- in_lock[g] SHALL be sampled at grant time;
- if it was 1, after the handshake the next IDLE arbitration SHALL grant g again if in_req[g] = 1, bypassing round-robin;
- otherwise round-robin SHALL apply;
- a stored lock SHALL be cleared by reset or by the first arbitration that does not regrant g.
REQ-028 Without RR_ARB32_LOCK_EN, the in_lock port and the lock logic SHALL NOT exist, and the behaviour SHALL be pure round-robin.

Verification
REQ-029 Reset, then in_req = 0x00000001, in_data[0] = 0xA5A5A5A5, out_ready = 1: the bench SHALL check out_valid one cycle later, out_sel = 0, out_data = 0xA5A5A5A5, and in_ack = 0x00000001 for 1 cycle.
REQ-030 in_req = 0xFFFFFFFF held, in_data slice i = i, out_ready = 1: the bench SHALL check out_sel sequence 0, 1, …, 31, 0 and out_data equal to out_sel on each handshake.
REQ-031 Single request from index 5 with out_ready = 0 for 10 cycles, while in_data[5] changes: the bench SHALL check out_valid held and out_data/out_sel frozen; out_ready = 1 then completes, and the FSM returns to IDLE.
REQ-032 ptr = 30 (after a grant to 30), in_req = 0x80000001: the bench SHALL check grant 31, then 0 (wrap).
REQ-033 rst asserted during GRANT with out_ready = 0: the bench SHALL check out_valid = 0 next cycle; with in_req = 0x00000104, the next grant SHALL be index 2.
REQ-034 With RR_ARB32_LOCK_EN, in_req = 0x00000003 and in_lock = 0x00000001: the bench SHALL check grants 0, 0, 0; then with in_lock = 0, grants 0 then 1.
